competition_sequencer: RTL

Plays back the competition question bank one entry at a time. For each question it reads a 21-bit entry, dispatches the operands to the calculation datapath over a valid/ready handshake and captures the reference result. It then waits, under a per-question time limit, for the player's answer, judges it and accumulates a score. It sits between the question-entry block's bank and the shared arithmetic unit, and drives the competition-mode scoreboard display.

---
 rtl/comp_pkg.sv | 50 +++++
 rtl/question_timer.sv | 48 ++++
 rtl/competition_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/comp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : comp_pkg                                                     |
// | Description : Shared definitions for the competition sequencer: bank       |
// |               geometry, question-entry field slices, mode codes and the    |
// |               sequencer state encoding.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package comp_pkg;

  // Bank geometry, shared with the question-entry block
  localparam int BANK_DEPTH = 50;
  localparam int ADDR_W     = 6;
  localparam logic [ADDR_W-1:0] BANK_DEPTH_W = ADDR_W'(BANK_DEPTH);

  // Question-entry field slices: {mode[2:0], op[1:0], a[7:0], b[7:0]}
  localparam int MODE_HI = 20;
  localparam int MODE_LO = 18;
  localparam int OP_HI   = 17;
  localparam int OP_LO   = 16;
  localparam int A_HI    = 15;
  localparam int A_LO    = 8;
  localparam int B_HI    = 7;
  localparam int B_LO    = 0;

  // Mode codes understood by the arithmetic unit
  localparam logic [2:0] MODE_1 = 3'd1;
  localparam logic [2:0] MODE_2 = 3'd2;
  localparam logic [2:0] MODE_3 = 3'd3;
  localparam logic [2:0] MODE_4 = 3'd4;
  localparam logic [2:0] MODE_5 = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_LOAD     = 3'd2,
    S_DISPATCH = 3'd3,
    S_WAIT_RES = 3'd4,
    S_WAIT_ANS = 3'd5,
    S_JUDGE    = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  // An entry whose mode is not one of the five codes is never dispatched
  function automatic logic mode_valid(input logic [2:0] mode);
    return (mode inside {MODE_1, MODE_2, MODE_3, MODE_4, MODE_5});
  endfunction

endpackage
`default_nettype wire

// File: rtl/question_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : question_timer                                               |
// | Description : Per-question millisecond tick counter. Saturates at          |
// |               TIME_LIMIT and flags expiry until cleared.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk      in   system clock                                               |
// |   reset    in   asynchronous active-high reset                             |
// |   clear    in   synchronous clear of the tick count                        |
// |   enable   in   count ticks while high                                     |
// |   tick_1ms in   one-cycle pulse per millisecond                            |
// |   expired  out  count has reached TIME_LIMIT                               |
// +----------------------------------------------------------------------------+
module question_timer #(
  parameter int TIME_LIMIT = 10000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic tick_1ms,
  output logic expired
);

  localparam int CNT_W = $clog2(TIME_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_W = CNT_W'(TIME_LIMIT);

  logic [CNT_W-1:0] r_count;
  logic             w_at_limit;

  assign w_at_limit = (r_count == LIMIT_W);
  assign expired    = w_at_limit;

  // Saturating so that a late tick after expiry cannot wrap the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && tick_1ms && !w_at_limit) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/competition_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : competition_sequencer                                        |
// | Description : Plays the question bank back one entry at a time: fetches    |
// |               an entry, dispatches its operands to the arithmetic unit,    |
// |               captures the reference result, waits (time-limited) for the  |
// |               player's answer, judges it and keeps score.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, reset            clock, asynchronous active-high reset              |
// |   start, abort          run control pulses (abort has priority)            |
// |   q_count               number of valid bank entries                       |
// |   tick_1ms              millisecond pulse for the answer timer             |
// |   bank_rd_en/addr/data  bank read port, data one cycle after the strobe    |
// |   alu_valid/ready       operand handshake to the arithmetic unit           |
// |   alu_mode/op/a/b       operands of the current question                   |
// |   res_valid, res        reference result from the arithmetic unit          |
// |   ans_valid, ans        player answer strobe and value                     |
// |   q_index, score        current question and number of correct answers     |
// |   busy, done            run status                                         |
// |   last_correct          verdict of the most recent question                |
// |   timed_out             most recent question expired                       |
// +----------------------------------------------------------------------------+
module competition_sequencer
  import comp_pkg::*;
#(
  parameter int ENTRY_W    = 21,
  parameter int TIME_LIMIT = 10000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  q_count,
  input  logic               tick_1ms,
  output logic               bank_rd_en,
  output logic [ADDR_W-1:0]  bank_addr,
  input  logic [ENTRY_W-1:0] bank_data,
  output logic               alu_valid,
  input  logic               alu_ready,
  output logic [2:0]         alu_mode,
  output logic [1:0]         alu_op,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  input  logic               res_valid,
  input  logic [15:0]        res,
  input  logic               ans_valid,
  input  logic [15:0]        ans,
  output logic [ADDR_W-1:0]  q_index,
  output logic [ADDR_W-1:0]  score,
  output logic               busy,
  output logic               done,
  output logic               last_correct,
  output logic               timed_out
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_q_index;
  logic [ADDR_W-1:0]   r_score;
  logic [ADDR_W-1:0]   r_count;
  logic [ADDR_W-1:0]   r_bank_addr;
  logic [ENTRY_W-1:0]  r_entry;
  logic [15:0]         r_result;
  logic [15:0]         r_ans;
  logic                r_ans_latched;
  logic                r_timeout;
  logic                r_bank_rd_en;
  logic                r_alu_valid;
  logic                r_busy;
  logic                r_done;
  logic                r_last_correct;
  logic                r_timed_out;

  logic [ADDR_W-1:0]   w_eff_count;
  logic [ADDR_W-1:0]   w_next_index;
  logic                w_armed;
  logic                w_expired;
  logic                w_timer_clear;
  logic                w_correct;

  assign w_eff_count   = (q_count > BANK_DEPTH_W) ? BANK_DEPTH_W : q_count;
  assign w_next_index  = r_q_index + ADDR_W'(1);
  // Answer window and timer window coincide: DISPATCH through WAIT_ANS
  assign w_armed       = (r_state == S_DISPATCH) || (r_state == S_WAIT_RES) ||
                         (r_state == S_WAIT_ANS);
  // Clearing throughout LOAD guarantees a zero count on entry to DISPATCH
  assign w_timer_clear = (r_state == S_LOAD);
  assign w_correct     = r_ans_latched && (r_ans == r_result) && !r_timeout;

  question_timer #(
    .TIME_LIMIT (TIME_LIMIT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_timer_clear),
    .enable   (w_armed),
    .tick_1ms (tick_1ms),
    .expired  (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_q_index      <= '0;
      r_score        <= '0;
      r_count        <= '0;
      r_bank_addr    <= '0;
      r_entry        <= '0;
      r_result       <= '0;
      r_ans          <= '0;
      r_ans_latched  <= 1'b0;
      r_timeout      <= 1'b0;
      r_bank_rd_en   <= 1'b0;
      r_alu_valid    <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_last_correct <= 1'b0;
      r_timed_out    <= 1'b0;
    end else begin
      // Read strobe is a single-cycle pulse set only on entry to FETCH
      r_bank_rd_en <= 1'b0;

      if (abort) begin
        r_state     <= S_IDLE;
        r_alu_valid <= 1'b0;
        r_busy      <= 1'b0;
        r_done      <= 1'b0;
      end else begin
        // First answer inside the window wins
        if (w_armed && ans_valid && !r_ans_latched) begin
          r_ans         <= ans;
          r_ans_latched <= 1'b1;
        end

        case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              r_q_index      <= '0;
              r_score        <= '0;
              r_last_correct <= 1'b0;
              r_timed_out    <= 1'b0;
              r_count        <= w_eff_count;
              if (w_eff_count == '0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_state      <= S_FETCH;
                r_done       <= 1'b0;
                r_busy       <= 1'b1;
                r_bank_rd_en <= 1'b1;
                r_bank_addr  <= '0;
              end
            end
          end

          S_FETCH: begin
            r_state <= S_LOAD;
          end

          S_LOAD: begin
            r_entry       <= bank_data;
            r_ans_latched <= 1'b0;
            r_timeout     <= 1'b0;
            if (mode_valid(bank_data[MODE_HI:MODE_LO])) begin
              r_state     <= S_DISPATCH;
              r_alu_valid <= 1'b1;
            end else begin
              // No answer window opens, so the verdict comes out wrong
              r_state <= S_JUDGE;
            end
          end

          S_DISPATCH: begin
            if (w_expired) begin
              r_timeout   <= 1'b1;
              r_alu_valid <= 1'b0;
              r_state     <= S_JUDGE;
            end else if (alu_ready) begin
              r_alu_valid <= 1'b0;
              r_state     <= S_WAIT_RES;
            end
          end

          S_WAIT_RES: begin
            if (w_expired) begin
              r_timeout <= 1'b1;
              r_state   <= S_JUDGE;
            end else if (res_valid) begin
              r_result <= res;
              r_state  <= S_WAIT_ANS;
            end
          end

          S_WAIT_ANS: begin
            // An answer arriving this cycle is latched on the same edge
            if (w_expired) begin
              r_timeout <= 1'b1;
              r_state   <= S_JUDGE;
            end else if (r_ans_latched || ans_valid) begin
              r_state <= S_JUDGE;
            end
          end

          S_JUDGE: begin
            r_last_correct <= w_correct;
            r_timed_out    <= r_timeout;
            if (w_correct) begin
              r_score <= r_score + ADDR_W'(1);
            end
            r_q_index <= w_next_index;
            if (w_next_index == r_count) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state      <= S_FETCH;
              r_bank_rd_en <= 1'b1;
              r_bank_addr  <= w_next_index;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bank_rd_en   = r_bank_rd_en;
  assign bank_addr    = r_bank_addr;
  assign alu_valid    = r_alu_valid;
  assign alu_mode     = r_entry[MODE_HI:MODE_LO];
  assign alu_op       = r_entry[OP_HI:OP_LO];
  assign alu_a        = r_entry[A_HI:A_LO];
  assign alu_b        = r_entry[B_HI:B_LO];
  assign q_index      = r_q_index;
  assign score        = r_score;
  assign busy         = r_busy;
  assign done         = r_done;
  assign last_correct = r_last_correct;
  assign timed_out    = r_timed_out;

endmodule
`default_nettype wire
